// File: rtl/puf_race_launcher_pkg.sv
// rtl/puf_race_launcher_pkg.sv - shared state encodings and default parameters for the arbiter PUF launcher
package puf_race_launcher_pkg;

    localparam int CHAL_W_DEF      = 32;
    localparam int SETTLE_CYC_DEF  = 4;
    localparam int RESP_SETTLE_DEF = 8;
    localparam int VOTES_DEF       = 5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_LAUNCH  = 3'd2,
        S_SAMPLE  = 3'd3,
        S_RECOVER = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/puf_sync_2ff.sv
// rtl/puf_sync_2ff.sv - two-flop synchronizer bringing the arbiter output into the Clk domain
module puf_sync_2ff (
    input  logic Clk,
    input  logic Reset,
    input  logic ArbQ,
    output logic ArbQ_s
);

    logic meta;

    // First flop may go metastable; second flop gives it a full cycle to resolve
    always_ff @(posedge Clk) begin
        if (Reset) begin
            meta   <= 1'b0;
            ArbQ_s <= 1'b0;
        end else begin
            meta   <= ArbQ;
            ArbQ_s <= meta;
        end
    end

endmodule

// File: rtl/puf_race_launcher.sv
// rtl/puf_race_launcher.sv - sequences one arbiter PUF evaluation (optional PUF_MAJORITY_VOTE_EN)
module puf_race_launcher
    import puf_race_launcher_pkg::*;
#(
    parameter int CHAL_W      = CHAL_W_DEF,
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int RESP_SETTLE = RESP_SETTLE_DEF,
    parameter int VOTES       = VOTES_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ChalValid,
    output logic              ChalReady,
    input  logic [CHAL_W-1:0] Challenge,
    output logic [CHAL_W-1:0] ChalOut,
    output logic              Launch,
    input  logic              ArbQ,
    output logic              RespValid,
    output logic              Response,
    input  logic              RespReady,
    output logic              Busy
);

    localparam int CW = $clog2(max_int(SETTLE_CYC, RESP_SETTLE) + 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] RESP_LOAD   = CW'(RESP_SETTLE - 1);

    if (SETTLE_CYC < 1 || RESP_SETTLE < 3 || VOTES < 1 || (VOTES % 2) == 0) begin : g_param_check
        $error("puf_race_launcher: illegal parameter set");
    end

    state_t        state;
    logic [CW-1:0] cnt;
    logic          arbq_s;

`ifdef PUF_MAJORITY_VOTE_EN
    localparam int VW = $clog2(VOTES + 1);
    localparam logic [VW-1:0] VOTE_LAST = VW'(VOTES - 1);
    localparam logic [VW-1:0] VOTE_HALF = VW'(VOTES / 2);

    logic [VW-1:0] vote_cnt;
    logic [VW-1:0] ones;
`else
    logic          eval_bit;
`endif

    puf_sync_2ff u_sync (
        .Clk    (Clk),
        .Reset  (Reset),
        .ArbQ   (ArbQ),
        .ArbQ_s (arbq_s)
    );

    // Evaluation sequencer: every output is registered and the cycle counter reloads on each state entry
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ChalOut   <= '0;
            Launch    <= 1'b0;
            RespValid <= 1'b0;
            Response  <= 1'b0;
            ChalReady <= 1'b1;
            Busy      <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
            vote_cnt  <= '0;
            ones      <= '0;
`else
            eval_bit  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (ChalValid && ChalReady) begin
                        ChalOut   <= Challenge;
                        state     <= S_SETUP;
                        cnt       <= SETTLE_LOAD;
                        ChalReady <= 1'b0;
                        Busy      <= 1'b1;
`ifdef PUF_MAJORITY_VOTE_EN
                        vote_cnt  <= '0;
                        ones      <= '0;
`endif
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        state  <= S_LAUNCH;
                        cnt    <= RESP_LOAD;
                        Launch <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_LAUNCH: begin
                    if (cnt == '0) begin
                        state  <= S_SAMPLE;
                        cnt    <= '0;
                        Launch <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_SAMPLE: begin
`ifdef PUF_MAJORITY_VOTE_EN
                    ones     <= ones + VW'(arbq_s);
`else
                    eval_bit <= arbq_s;
`endif
                    state    <= S_RECOVER;
                    cnt      <= SETTLE_LOAD;
                end
                S_RECOVER: begin
                    if (cnt == '0) begin
`ifdef PUF_MAJORITY_VOTE_EN
                        if (vote_cnt == VOTE_LAST) begin
                            state     <= S_DONE;
                            cnt       <= '0;
                            RespValid <= 1'b1;
                            Response  <= (ones > VOTE_HALF);
                        end else begin
                            vote_cnt  <= vote_cnt + 1'b1;
                            state     <= S_LAUNCH;
                            cnt       <= RESP_LOAD;
                            Launch    <= 1'b1;
                        end
`else
                        state     <= S_DONE;
                        cnt       <= '0;
                        RespValid <= 1'b1;
                        Response  <= eval_bit;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (RespReady) begin
                        state     <= S_IDLE;
                        cnt       <= '0;
                        RespValid <= 1'b0;
                        ChalReady <= 1'b1;
                        Busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cnt       <= '0;
                    Launch    <= 1'b0;
                    RespValid <= 1'b0;
                    ChalReady <= 1'b1;
                    Busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_race_launcher.sv
// tb/tb_puf_race_launcher.sv - scoreboard bench for puf_race_launcher (T5 only with PUF_MAJORITY_VOTE_EN)
module tb_puf_race_launcher;

    localparam int CHAL_W      = 32;
    localparam int SETTLE_CYC  = 4;
    localparam int RESP_SETTLE = 8;
    localparam int VOTES       = 5;
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int EXP_LAT = 69;
    localparam int NEV     = 5;
`else
    localparam int EXP_LAT = 17;
    localparam int NEV     = 1;
`endif

    logic              Clk;
    logic              Reset;
    logic              ChalValid;
    logic              ChalReady;
    logic [CHAL_W-1:0] Challenge;
    logic [CHAL_W-1:0] ChalOut;
    logic              Launch;
    logic              ArbQ;
    logic              RespValid;
    logic              Response;
    logic              RespReady;
    logic              Busy;

    puf_race_launcher #(
        .CHAL_W      (CHAL_W),
        .SETTLE_CYC  (SETTLE_CYC),
        .RESP_SETTLE (RESP_SETTLE),
        .VOTES       (VOTES)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .ChalValid (ChalValid),
        .ChalReady (ChalReady),
        .Challenge (Challenge),
        .ChalOut   (ChalOut),
        .Launch    (Launch),
        .ArbQ      (ArbQ),
        .RespValid (RespValid),
        .Response  (Response),
        .RespReady (RespReady),
        .Busy      (Busy)
    );

    typedef struct {
        logic        resp;
        logic [31:0] chal;
        int          acc;
    } exp_t;

    exp_t sb[$];
    logic arb_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_rise = 0;
    exp_t mon_e;
    logic rv_q = 1'b0;
    logic rv_q2 = 1'b0;
    logic la_q = 1'b0;
    int   hi_run = 0;
    int   lo_run = 0;
    logic [31:0] chal_at_rise = '0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Arbiter model: Q resolves shortly after the race edge, rearms when Launch drops
    always @(posedge Launch) begin
        #2;
        ArbQ = (arb_q.size() != 0) ? arb_q.pop_front() : 1'b1;
    end
    always @(negedge Launch) ArbQ = 1'b0;

    // Response monitor: pops the scoreboard on each RespValid rise
    always @(negedge Clk) begin
        if (RespValid && !rv_q) begin
            last_rise = cyc;
            check("resp_has_expectation", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("response", Response, mon_e.resp);
                check("chal_out_at_resp", ChalOut, mon_e.chal);
                check("latency", cyc - mon_e.acc, EXP_LAT);
            end
        end
        rv_q = RespValid;
    end

    // Launch pulse shape monitor
    always @(negedge Clk) begin
        if (Reset) begin
            hi_run = 0;
            lo_run = 0;
        end else begin
            if (Launch && !la_q) begin
                check("launch_low_before", lo_run >= SETTLE_CYC, 1);
                hi_run = 0;
                chal_at_rise = ChalOut;
            end
            if (Launch) begin
                hi_run++;
                check("chalout_stable_launch", ChalOut, chal_at_rise);
            end
            if (!Launch && la_q) check("launch_high_len", hi_run, RESP_SETTLE);
            if (Launch) lo_run = 0;
            else if (Busy) lo_run++;
            if (RespValid && !rv_q2) check("launch_low_after", lo_run >= SETTLE_CYC, 1);
        end
        la_q = Launch;
        rv_q2 = RespValid;
    end

    task automatic push_arb(input logic b);
        for (int i = 0; i < NEV; i++) arb_q.push_back(b);
    endtask

    task automatic issue(input logic [31:0] c, input logic r, output int acc);
        int n;
        n = 0;
        while (!ChalReady && n < 300) begin
            @(negedge Clk);
            n++;
        end
        check("chal_ready_wait", ChalReady, 1);
        ChalValid = 1'b1;
        Challenge = c;
        @(negedge Clk);
        acc = cyc;
        sb.push_back('{resp: r, chal: c, acc: cyc});
        ChalValid = 1'b0;
        check("busy_after_accept", Busy, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || RespValid) && n < 500) begin
            @(negedge Clk);
            n++;
        end
        check("drain_done", (sb.size() == 0) && !RespValid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc1;
        int acc2;
        int n;

        Reset     = 1'b1;
        ChalValid = 1'b0;
        Challenge = '0;
        RespReady = 1'b0;
        ArbQ      = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_launch", Launch, 0);
        check("rst_resp_valid", RespValid, 0);
        check("rst_response", Response, 0);
        check("rst_chal_ready", ChalReady, 1);
        check("rst_busy", Busy, 0);
        check("rst_chal_out", ChalOut, 0);
        Reset = 1'b0;
        @(negedge Clk);

        // T1: reset mid-LAUNCH
        push_arb(1'b1);
        issue(32'hDEAD_BEEF, 1'b1, acc1);
        n = 0;
        while (!Launch && n < 100) begin
            @(negedge Clk);
            n++;
        end
        check("t1_launch_seen", Launch, 1);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        sb.delete();
        @(negedge Clk);
        check("t1_launch", Launch, 0);
        check("t1_resp_valid", RespValid, 0);
        check("t1_chal_ready", ChalReady, 1);
        check("t1_busy", Busy, 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        arb_q.delete();
        @(negedge Clk);

        // T2 / T4: single evaluation, Launch shape checked by monitor
        RespReady = 1'b1;
        push_arb(1'b1);
        issue(32'hA5A5_0F0F, 1'b1, acc1);
        check("t2_chal_out", ChalOut, 32'hA5A5_0F0F);
        drain();
        check("t2_chal_out_held", ChalOut, 32'hA5A5_0F0F);
        check("t2_idle_ready", ChalReady, 1);

        // T3: response held while RespReady low; new challenge ignored
        RespReady = 1'b0;
        push_arb(1'b0);
        issue(32'h1234_5678, 1'b0, acc1);
        n = 0;
        while (!RespValid && n < 200) begin
            @(negedge Clk);
            n++;
        end
        check("t3_resp_valid_seen", RespValid, 1);
        for (int i = 0; i < 20; i++) begin
            if (i == 2) begin
                ChalValid = 1'b1;
                Challenge = 32'hFFFF_FFFF;
            end
            @(negedge Clk);
            check("t3_hold_valid", RespValid, 1);
            check("t3_hold_response", Response, 0);
            check("t3_hold_chal_ready", ChalReady, 0);
            check("t3_hold_chal_out", ChalOut, 32'h1234_5678);
        end
        ChalValid = 1'b0;
        RespReady = 1'b1;
        @(negedge Clk);
        check("t3_release_valid", RespValid, 0);
        check("t3_release_ready", ChalReady, 1);
        check("t3_release_busy", Busy, 0);
        drain();

`ifdef PUF_MAJORITY_VOTE_EN
        // T5: majority vote patterns
        arb_q.push_back(1'b1); arb_q.push_back(1'b0); arb_q.push_back(1'b1);
        arb_q.push_back(1'b1); arb_q.push_back(1'b0);
        issue(32'h3C3C_3C3C, 1'b1, acc1);
        drain();
        arb_q.push_back(1'b0); arb_q.push_back(1'b0); arb_q.push_back(1'b1);
        arb_q.push_back(1'b0); arb_q.push_back(1'b1);
        issue(32'hC3C3_C3C3, 1'b0, acc1);
        drain();
`endif

        // T6: back-to-back with RespReady tied high
        RespReady = 1'b1;
        push_arb(1'b1);
        push_arb(1'b0);
        issue(32'hC0DE_0001, 1'b1, acc1);
        issue(32'hC0DE_0002, 1'b0, acc2);
        check("t6_accept_gap", acc2 - last_rise, 2);
        drain();
        check("t6_chal_out", ChalOut, 32'hC0DE_0002);

        repeat (3) @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
